kernel_bc_start_sched: RTL and testbench

// Start-token scheduler for the kernel_bc dataflow region. Takes the block-level ap_start and fans
// one start token per iteration into NUM_CH start_for FIFOs (1-bit, depth 4, write side: full_n/write/din).

---
 rtl/kernel_bc_start_sched_if.sv | 21 ++
 rtl/kernel_bc_start_sched.sv | 120 ++++++++++++
 tb/tb_kernel_bc_start_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_bc_start_sched_if.sv
// Write side of the per-channel start_for FIFOs fed by the start-token scheduler.
// One bit per channel on every signal.
interface kernel_bc_start_sched_if #(
    parameter int unsigned NUM_CH = 2
);
    logic [NUM_CH-1:0] start_full_n;
    logic [NUM_CH-1:0] start_write;
    logic [NUM_CH-1:0] start_din;

    modport master (
        input  start_full_n,
        output start_write,
        output start_din
    );

    modport slave (
        output start_full_n,
        input  start_write,
        input  start_din
    );
endinterface

// File: rtl/kernel_bc_start_sched.sv
// Start-token scheduler for the kernel_bc dataflow region: one start token per iteration fanned
// into NUM_CH start FIFOs, with a bounded count of iterations in flight.
module kernel_bc_start_sched #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned OUT_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [CNT_W-1:0]        iter_count,
    output logic                    ap_idle,
    output logic                    ap_ready,
    output logic                    ap_done,
    kernel_bc_start_sched_if.master start,
    input  logic                    sink_done,
    output logic [OUT_W-1:0]        outstanding,
    output logic                    err_underflow
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [NUM_CH-1:0]  sent_q, sent_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               err_q, err_d;
    logic               ap_idle_q, ap_ready_q, ap_done_q;
    logic               ap_idle_d, ap_ready_d, ap_done_d;
    logic [NUM_CH-1:0]  write_c, din_c, accepted;
    logic               complete, eligible;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        sent_d        = sent_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        ap_ready_d    = 1'b0;
        write_c       = '0;
        din_c         = '0;
        accepted      = '0;
        complete      = 1'b0;
        eligible      = outstanding_q < OUT_W'(MAX_OUT);

        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    remaining_d = iter_count;
                    state_d     = (iter_count == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                // Channels that already took this token are never re-written.
                if (eligible) write_c = ~sent_q;
                din_c    = {NUM_CH{remaining_q == CNT_W'(1)}};
                accepted = write_c & start.start_full_n;
                if (&(sent_q | accepted)) begin
                    complete = 1'b1;
                    sent_d   = '0;
                    if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        ap_ready_d = 1'b1;
                        state_d    = StDrain;
                    end
                end else begin
                    sent_d = sent_q | accepted;
                end
            end
            StDrain: begin
                if (outstanding_q == '0 && !sink_done) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (complete && !sink_done) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!complete && sink_done) begin
            if (outstanding_q == '0) err_d = 1'b1;
            else outstanding_d = outstanding_q - OUT_W'(1);
        end

        ap_done_d = (state_q == StDone);
        // Idle rises only after the ap_done cycle has passed.
        ap_idle_d = (state_d == StIdle) && (state_q != StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            sent_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            ap_idle_q     <= 1'b1;
            ap_ready_q    <= 1'b0;
            ap_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            sent_q        <= sent_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            ap_idle_q     <= ap_idle_d;
            ap_ready_q    <= ap_ready_d;
            ap_done_q     <= ap_done_d;
        end
    end

    assign start.start_write = reset ? '0 : write_c;
    assign start.start_din   = din_c;
    assign ap_idle           = ap_idle_q;
    assign ap_ready          = ap_ready_q;
    assign ap_done           = ap_done_q;
    assign outstanding       = outstanding_q;
    assign err_underflow     = err_q;

endmodule

// File: tb/tb_kernel_bc_start_sched.sv
// Bench for kernel_bc_start_sched: directed scenarios, an event-level model checked every cycle,
// and literal expectations on token counts, payloads and pulse timing.
module tb_kernel_bc_start_sched;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned OUT_W   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ap_start = 1'b0;
    logic [CNT_W-1:0] iter_count = '0;
    logic             ap_idle, ap_ready, ap_done;
    logic             sink_done = 1'b0;
    logic [OUT_W-1:0] outstanding;
    logic             err_underflow;

    kernel_bc_start_sched_if #(.NUM_CH(NUM_CH)) start_if ();

    kernel_bc_start_sched #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .MAX_OUT(MAX_OUT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .iter_count   (iter_count),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .start        (start_if.master),
        .sink_done    (sink_done),
        .outstanding  (outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: tokens left to issue, iterations in flight, channels delivered for current token,
    // busy run flag, wrap-up countdown (2: done state, 1: ap_done pulse).
    int       m_left = 0;
    int       m_inflight = 0;
    logic [1:0] m_got = '0;
    bit       m_busy = 0;
    int       m_w = 0;
    bit       m_ready = 0;
    bit       m_idle = 1;
    bit       m_err = 0;
    logic [1:0] comp_hist = '0;
    bit       auto_sink = 0;

    int   acc0 = 0, acc1 = 0, ready_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic din_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        logic [1:0] exp_wr, acc;
        bit comp;
        int n_left, n_inf, n_w;
        bit n_busy;
        exp_wr = (!reset && m_busy && m_left > 0 && m_inflight < int'(MAX_OUT)) ? ~m_got : 2'b00;
        chk("ap_idle", 32'(ap_idle), 32'(m_idle));
        chk("ap_ready", 32'(ap_ready), 32'(m_ready));
        chk("ap_done", 32'(ap_done), 32'(m_w == 1));
        chk("outstanding", 32'(outstanding), 32'(m_inflight));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        chk("start_write", 32'(start_if.start_write), 32'(exp_wr));
        if (exp_wr != 2'b00)
            chk("start_din", 32'(start_if.start_din), (m_left == 1) ? 32'd3 : 32'd0);

        if (start_if.start_write[0] & start_if.start_full_n[0]) begin
            acc0++;
            din_q.push_back(start_if.start_din[0]);
        end
        if (start_if.start_write[1] & start_if.start_full_n[1]) acc1++;
        if (ap_ready) ready_cnt++;
        if (ap_done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        if (reset) begin
            m_left = 0; m_inflight = 0; m_got = '0; m_busy = 0; m_w = 0;
            m_ready = 0; m_idle = 1; m_err = 0; comp_hist = '0;
        end else begin
            acc  = exp_wr & start_if.start_full_n;
            comp = (exp_wr != 2'b00) && ((m_got | acc) == 2'b11);
            n_inf = m_inflight;
            if (comp && !sink_done) n_inf = m_inflight + 1;
            else if (!comp && sink_done) begin
                if (m_inflight == 0) m_err = 1;
                else n_inf = m_inflight - 1;
            end
            m_ready = comp && (m_left == 1);
            m_got   = comp ? 2'b00 : (m_got | acc);
            n_left  = comp ? m_left - 1 : m_left;
            n_busy  = m_busy;
            n_w     = (m_w > 0) ? m_w - 1 : 0;
            if (m_busy && m_left == 0 && m_inflight == 0 && !sink_done) begin
                n_busy = 0;
                n_w    = 2;
            end else if (!m_busy && m_w != 2 && ap_start) begin
                if (iter_count == '0) n_w = 2;
                else begin
                    n_busy = 1;
                    n_left = int'(iter_count);
                end
            end
            m_left = n_left; m_inflight = n_inf; m_busy = n_busy; m_w = n_w;
            m_idle = !n_busy && (n_w == 0);
            comp_hist = {comp_hist[0], comp};
        end
        cyc++;
    endtask

    // Check at negedge, then move to just after the next rising edge to drive inputs.
    task automatic cycle();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
        if (auto_sink) sink_done = comp_hist[1];
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < limit) begin
            cycle();
            n++;
        end
        chk("ap_done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    int b0, b1, br, bd, s;

    initial begin
        start_if.start_full_n = 2'b11;
        repeat (3) cycle();
        chk("rst_idle", 32'(ap_idle), 32'd1);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_write", 32'(start_if.start_write), 32'd0);
        chk("rst_done", 32'(ap_done), 32'd0);
        reset = 1'b0;
        cycle();

        // Three iterations, sinks two cycles after each token.
        b0 = acc0; b1 = acc1; br = ready_cnt; bd = done_cnt; din_q.delete();
        auto_sink = 1; iter_count = 3; ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        wait_done(40);
        cycle();
        chk("s1_ch0_tokens", 32'(acc0 - b0), 32'd3);
        chk("s1_ch1_tokens", 32'(acc1 - b1), 32'd3);
        chk("s1_din_count", 32'(din_q.size()), 32'd3);
        if (din_q.size() == 3) begin
            chk("s1_din0", 32'(din_q[0]), 32'd0);
            chk("s1_din1", 32'(din_q[1]), 32'd0);
            chk("s1_din2", 32'(din_q[2]), 32'd1);
        end
        chk("s1_ready_pulses", 32'(ready_cnt - br), 32'd1);
        chk("s1_idle_back", 32'(ap_idle), 32'd1);

        // Channel 1 stalled for five cycles on the first token.
        b0 = acc0; b1 = acc1; br = ready_cnt;
        iter_count = 2; ap_start = 1'b1; start_if.start_full_n = 2'b01;
        cycle();
        ap_start = 1'b0;
        repeat (4) cycle();
        chk("s2_ch0_once", 32'(acc0 - b0), 32'd1);
        chk("s2_ch1_none", 32'(acc1 - b1), 32'd0);
        chk("s2_outstanding_held", 32'(outstanding), 32'd0);
        cycle();
        start_if.start_full_n = 2'b11;
        wait_done(60);
        chk("s2_ch0_tokens", 32'(acc0 - b0), 32'd2);
        chk("s2_ch1_tokens", 32'(acc1 - b1), 32'd2);
        chk("s2_ready_pulses", 32'(ready_cnt - br), 32'd1);

        // Outstanding cap with sinks withheld.
        auto_sink = 0; sink_done = 1'b0; b0 = acc0; br = ready_cnt;
        iter_count = 8; ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        repeat (10) cycle();
        chk("s3_cap_outstanding", 32'(outstanding), 32'd4);
        chk("s3_cap_tokens", 32'(acc0 - b0), 32'd4);
        sink_done = 1'b1;
        cycle();
        sink_done = 1'b0;
        repeat (3) cycle();
        chk("s3_one_more_token", 32'(acc0 - b0), 32'd5);
        chk("s3_refilled", 32'(outstanding), 32'd4);
        repeat (7) begin
            sink_done = 1'b1;
            cycle();
            sink_done = 1'b0;
            cycle();
        end
        wait_done(40);
        chk("s3_all_tokens", 32'(acc0 - b0), 32'd8);
        chk("s3_ready_pulses", 32'(ready_cnt - br), 32'd1);

        // Sink while idle is an underflow, sticky.
        cycle();
        sink_done = 1'b1;
        cycle();
        sink_done = 1'b0;
        chk("s4_err_set", 32'(err_underflow), 32'd1);
        chk("s4_outstanding_zero", 32'(outstanding), 32'd0);
        repeat (3) cycle();
        chk("s4_err_sticky", 32'(err_underflow), 32'd1);

        // Completion and sink in the same cycle leave outstanding unchanged.
        iter_count = 2; ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        cycle();
        sink_done = 1'b1;
        cycle();
        sink_done = 1'b0;
        chk("s4_same_cycle", 32'(outstanding), 32'd1);
        sink_done = 1'b1;
        cycle();
        sink_done = 1'b0;
        wait_done(20);

        // Zero iterations: ap_done two cycles after ap_start, nothing issued.
        cycle();
        b0 = acc0; b1 = acc1; br = ready_cnt;
        iter_count = 0; ap_start = 1'b1; s = cyc;
        cycle();
        ap_start = 1'b0;
        wait_done(10);
        chk("s5_done_latency", 32'(done_cyc - s), 32'd2);
        chk("s5_no_writes", 32'(acc0 - b0 + acc1 - b1), 32'd0);
        chk("s5_no_ready", 32'(ready_cnt - br), 32'd0);

        // Reset in the middle of a token with channel 0 already sent.
        cycle();
        iter_count = 3; ap_start = 1'b1; start_if.start_full_n = 2'b01;
        cycle();
        ap_start = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        chk("s6_write_in_reset", 32'(start_if.start_write), 32'd0);
        cycle();
        reset = 1'b0;
        chk("s6_idle_after", 32'(ap_idle), 32'd1);
        chk("s6_outstanding_after", 32'(outstanding), 32'd0);
        chk("s6_err_cleared", 32'(err_underflow), 32'd0);
        start_if.start_full_n = 2'b11; auto_sink = 1;
        b0 = acc0; b1 = acc1; br = ready_cnt;
        iter_count = 1; ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        wait_done(20);
        chk("s6_ch0_tokens", 32'(acc0 - b0), 32'd1);
        chk("s6_ch1_tokens", 32'(acc1 - b1), 32'd1);
        chk("s6_ready_pulses", 32'(ready_cnt - br), 32'd1);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
